mem_port_seq: RTL and testbench
===============================

MEM_PORT_SEQ -- requirements
Module: mem_port_seq

Interface
REQ-001 Parameter BURST, default 16, number of 16-bit elements moved per vector transfer; legal range 1-16.
REQ-002 Clk1  input  1  single system clock; all state changes on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on rising Clk1.
REQ-004 F_Req  input  1  instruction-fetch request, level, held until F_Valid.
REQ-005 F_Addr  input  16  fetch address, sampled on the grant cycle.
REQ-006 F_Valid  output  1  one-cycle pulse, F_Data holds the fetched word.
REQ-007 F_Data  output  16  fetched instruction word, holds until next fetch.
REQ-008 V_Req  input  1  vector transfer request, level, held until V_Done.
REQ-009 V_Wr  input  1  0 = vld (memory to vector), 1 = vst (vector to memory); sampled on grant.
REQ-010 V_Base  input  16  vector base address, sampled on grant.
REQ-011 V_Idx  output  4  element index currently addressed.
REQ-012 V_WrData  input  16  element V_Idx of the source vector register, valid in the same cycle as V_Idx.
REQ-013 V_RdValid  output  1  V_RdData holds element V_RdIdx.
REQ-014 V_RdData  output  16  loaded element.  V_RdIdx  output  4  index of loaded element.
REQ-015 V_Done  output  1  one-cycle pulse ending a vector transfer.
REQ-016 Addr  output  16  memory address.  RD  output  1  memory read strobe.  WR  output  1  memory write strobe.
REQ-017 DataOut  output  16  memory write data.  DataIn  input  16  memory read data, valid the cycle after RD=1.

Function
REQ-018 States: IDLE, F_RD, F_CAP, V_RD, V_DRAIN, V_WR, V_FIN; all outputs registered.
REQ-019 IDLE, only one request: grant it. Both F_Req and V_Req: grant the requester not granted last (round robin); after reset, last-granted = vector, so fetch wins first.
REQ-020 Fetch grant (IDLE->F_RD): Addr<=F_Addr, RD<=1.
REQ-021 F_RD->F_CAP: RD<=0. F_CAP->IDLE: F_Data<=DataIn, F_Valid<=1 for one cycle; F_Req sample to F_Valid = 3 cycles.
REQ-022 Vector grant with V_Wr=0 (IDLE->V_RD): index k=0, Addr<=V_Base, RD<=1, V_Idx<=0.
REQ-023 V_RD: one element per cycle; Addr = V_Base+k modulo 2^16 (wraps 16'hFFFF->16'h0000); after k=BURST-1, RD<=0 and go to V_DRAIN.
REQ-024 Every cycle after an RD=1 cycle of element k: V_RdData<=DataIn, V_RdIdx<=k, V_RdValid<=1; the last element lands in V_DRAIN.
REQ-025 V_DRAIN->V_FIN; V_FIN: V_Done<=1 for one cycle, then IDLE.
REQ-026 Vector grant with V_Wr=1 (IDLE->V_WR): V_Idx<=0; each V_WR cycle with V_Idx=k: Addr<=V_Base+k, DataOut<=V_WrData, WR<=1, V_Idx<=k+1.
REQ-027 After element BURST-1 is written, WR<=0, go to V_FIN; exactly BURST WR cycles with consecutive addresses.
REQ-028 A started transaction is never preempted; requests arriving mid-transaction wait in IDLE arbitration.
REQ-029 RD and WR never both 1; in IDLE both 0.
REQ-030 Request deasserted after grant: transaction still completes (no abort).
REQ-031 V_Done and F_Valid never pulse in the same cycle.

Reset
REQ-032 Reset=1 on any edge: state IDLE; Addr, DataOut, F_Data, V_RdData = 16'h0000; V_Idx, V_RdIdx = 0; RD, WR, F_Valid, V_RdValid, V_Done = 0; last-granted = vector.
REQ-033 Reset mid-transaction aborts it with no V_Done/F_Valid; the requester must re-request.

Verification
REQ-034 Fetch: F_Req=1, F_Addr=16'h0000, memory word 16'h7312 -> RD high 1 cycle at Addr 0, F_Valid 3 cycles later, F_Data=16'h7312.
REQ-035 vld: V_Base=16'h0100, mem[0x100+k]=k*3 -> 16 consecutive RD cycles, V_RdValid with V_RdIdx 0..15 and data 0..45, one V_Done.
REQ-036 vst wrap: V_Base=16'hFFF8, V_WrData=16'hA000+V_Idx -> WR addresses FFF8..FFFF then 0000..0007, DataOut A000..A00F.
REQ-037 Contention: F_Req and V_Req both 1 from reset -> fetch served first, then vector, then next fetch (alternation).
REQ-038 Reset at element 5 of vld -> next cycle RD=0, V_RdValid=0, all outputs at reset values, no V_Done.
REQ-039 Invariant check every cycle: RD&WR never 1; V_Done&F_Valid never 1.

Source files
------------

// File: rtl/mem_port_seq.sv
// mem_port_seq: single memory port shared by an instruction-fetch requester
// and a vector load/store requester. Round-robin arbitration in IDLE, then a
// non-preemptible transaction: one fetched word, or a burst of BURST
// consecutive 16-bit elements (addresses wrap modulo 2^16).
// All outputs are registered; memory read data arrives the cycle after RD.
module mem_port_seq #(
    parameter int BURST = 16
) (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic        F_Req,
    input  logic [15:0] F_Addr,
    output logic        F_Valid,
    output logic [15:0] F_Data,
    input  logic        V_Req,
    input  logic        V_Wr,
    input  logic [15:0] V_Base,
    output logic [3:0]  V_Idx,
    input  logic [15:0] V_WrData,
    output logic        V_RdValid,
    output logic [15:0] V_RdData,
    output logic [3:0]  V_RdIdx,
    output logic        V_Done,
    output logic [15:0] Addr,
    output logic        RD,
    output logic        WR,
    output logic [15:0] DataOut,
    input  logic [15:0] DataIn
);

    localparam logic [3:0] LAST_IDX = 4'(BURST - 1);

    typedef enum logic [2:0] {
        IDLE,
        F_RD,
        F_CAP,
        V_RD,
        V_DRAIN,
        V_WR,
        V_FIN
    } state_t;

    state_t      state;
    logic        last_vec;   // 1 when the vector requester won the last grant
    logic [15:0] base;       // vector base latched at grant (store path)
    logic        cap_pend;   // previous cycle issued a vector RD
    logic [3:0]  cap_idx;    // element index of that RD

    // Sequencer: arbitration, memory strobes, load capture and every output.
    // NOTE: non-blocking assignments throughout, so every register reads its
    // pre-edge value; a later assignment in the same pass (cap_pend inside
    // the case) overrides the default given above it.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            // NOTE: synchronous reset clears every register, including the
            // data holders, so a reset mid-transaction leaves no stale word.
            state     <= IDLE;
            last_vec  <= 1'b1;
            base      <= 16'h0000;
            cap_pend  <= 1'b0;
            cap_idx   <= 4'd0;
            Addr      <= 16'h0000;
            DataOut   <= 16'h0000;
            RD        <= 1'b0;
            WR        <= 1'b0;
            F_Valid   <= 1'b0;
            F_Data    <= 16'h0000;
            V_Idx     <= 4'd0;
            V_RdValid <= 1'b0;
            V_RdData  <= 16'h0000;
            V_RdIdx   <= 4'd0;
            V_Done    <= 1'b0;
        end else begin
            F_Valid  <= 1'b0;
            V_Done   <= 1'b0;
            cap_pend <= 1'b0;

            // DataIn this cycle answers the vector RD issued one cycle ago.
            V_RdValid <= cap_pend;
            if (cap_pend) begin
                V_RdData <= DataIn;
                V_RdIdx  <= cap_idx;
            end

            case (state)
                IDLE: begin
                    RD <= 1'b0;
                    WR <= 1'b0;
                    if (F_Req && (!V_Req || last_vec)) begin
                        last_vec <= 1'b0;
                        Addr     <= F_Addr;
                        RD       <= 1'b1;
                        state    <= F_RD;
                    end else if (V_Req) begin
                        last_vec <= 1'b1;
                        base     <= V_Base;
                        V_Idx    <= 4'd0;
                        if (V_Wr) begin
                            state <= V_WR;
                        end else begin
                            Addr  <= V_Base;
                            RD    <= 1'b1;
                            state <= V_RD;
                        end
                    end
                end

                F_RD: begin
                    RD    <= 1'b0;
                    state <= F_CAP;
                end

                F_CAP: begin
                    F_Data  <= DataIn;
                    F_Valid <= 1'b1;
                    state   <= IDLE;
                end

                V_RD: begin
                    cap_pend <= 1'b1;
                    cap_idx  <= V_Idx;
                    if (V_Idx == LAST_IDX) begin
                        RD    <= 1'b0;
                        state <= V_DRAIN;
                    end else begin
                        Addr  <= Addr + 16'd1;
                        V_Idx <= V_Idx + 4'd1;
                    end
                end

                V_DRAIN: begin
                    state <= V_FIN;
                end

                V_WR: begin
                    Addr    <= base + {12'h000, V_Idx};
                    DataOut <= V_WrData;
                    WR      <= 1'b1;
                    V_Idx   <= V_Idx + 4'd1;
                    if (V_Idx == LAST_IDX) begin
                        state <= V_FIN;
                    end
                end

                V_FIN: begin
                    WR     <= 1'b0;
                    V_Done <= 1'b1;
                    state  <= IDLE;
                end

                default: begin
                    RD    <= 1'b0;
                    WR    <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_seq.sv
// Self-checking bench for mem_port_seq: a memory device, requesters, a
// transaction-level reference model that schedules the expected output
// activity per cycle, a compare process on the falling edge, directed
// scenarios with literal expectations, and a randomized phase.
module tb_mem_port_seq;

    localparam int BURST = 16;

    logic        Clk1;
    logic        Reset;
    logic        F_Req;
    logic [15:0] F_Addr;
    logic        F_Valid;
    logic [15:0] F_Data;
    logic        V_Req;
    logic        V_Wr;
    logic [15:0] V_Base;
    logic [3:0]  V_Idx;
    logic [15:0] V_WrData;
    logic        V_RdValid;
    logic [15:0] V_RdData;
    logic [3:0]  V_RdIdx;
    logic        V_Done;
    logic [15:0] Addr;
    logic        RD;
    logic        WR;
    logic [15:0] DataOut;
    logic [15:0] DataIn;

    logic [15:0] wr_seed;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_seq #(.BURST(BURST)) dut (
        .Clk1      (Clk1),
        .Reset     (Reset),
        .F_Req     (F_Req),
        .F_Addr    (F_Addr),
        .F_Valid   (F_Valid),
        .F_Data    (F_Data),
        .V_Req     (V_Req),
        .V_Wr      (V_Wr),
        .V_Base    (V_Base),
        .V_Idx     (V_Idx),
        .V_WrData  (V_WrData),
        .V_RdValid (V_RdValid),
        .V_RdData  (V_RdData),
        .V_RdIdx   (V_RdIdx),
        .V_Done    (V_Done),
        .Addr      (Addr),
        .RD        (RD),
        .WR        (WR),
        .DataOut   (DataOut),
        .DataIn    (DataIn)
    );

    initial begin
        Clk1 = 1'b0;
        forever #5 Clk1 = ~Clk1;
    end

    // Source vector register: element k of the current store is wr_seed + k.
    assign V_WrData = wr_seed + {12'h000, V_Idx};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Power-on memory image; the directed scenarios rely on 0x0000 and 0x0100..0x010F.
    function automatic logic [15:0] init_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h7312;
        if (a >= 16'h0100 && a <= 16'h010F) return 16'((a - 16'h0100) * 16'd3);
        return 16'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // ---------------- memory device ----------------
    logic [15:0] dev_mem [logic [15:0]];

    function automatic logic [15:0] dev_read(input logic [15:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
    endfunction

    // Read data is only meaningful the cycle after RD; otherwise drive noise.
    always @(posedge Clk1) begin
        if (RD === 1'b1) DataIn <= dev_read(Addr);
        else             DataIn <= 16'($urandom);
        if (WR === 1'b1) dev_mem[Addr] = DataOut;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        fv;
        logic        rv;
        logic        done;
        logic        chk_idx;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] fdata;
        logic [15:0] rdata;
        logic [3:0]  ridx;
        logic [3:0]  vidx;
    } exp_t;

    exp_t        sched [64];
    int          cyc = 0;
    int          free_at = 0;
    bit          m_last_vec = 1'b1;
    logic [15:0] model_mem [logic [15:0]];

    function automatic logic [15:0] model_read(input logic [15:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_word(a);
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) sched[i] = '0;
    end

    // Edge n starts cycle n. A grant at edge g expects:
    //   fetch: RD in g, F_Valid in g+2, free again at edge g+3
    //   vld:   RD elem k in g+k, V_RdValid elem k in g+k+2, V_Done in g+N+2
    //   vst:   WR elem k in g+k+1, V_Done in g+N+1
    always @(posedge Clk1) begin
        int g;
        logic [15:0] a;
        cyc++;
        g = cyc;
        sched[(g - 1) % 64] = '0;
        if (Reset === 1'b1) begin
            for (int i = 0; i < 32; i++) sched[(g + i) % 64] = '0;
            free_at    = g + 1;
            m_last_vec = 1'b1;
        end else if (g >= free_at && (F_Req || V_Req)) begin
            if (F_Req && (!V_Req || m_last_vec)) begin
                m_last_vec = 1'b0;
                sched[g % 64].rd         = 1'b1;
                sched[g % 64].addr       = F_Addr;
                sched[(g + 2) % 64].fv    = 1'b1;
                sched[(g + 2) % 64].fdata = model_read(F_Addr);
                free_at = g + 3;
            end else begin
                m_last_vec = 1'b1;
                for (int k = 0; k < BURST; k++) begin
                    a = 16'(V_Base + 16'(k));
                    sched[(g + k) % 64].chk_idx = 1'b1;
                    sched[(g + k) % 64].vidx    = 4'(k);
                    if (!V_Wr) begin
                        sched[(g + k) % 64].rd       = 1'b1;
                        sched[(g + k) % 64].addr     = a;
                        sched[(g + k + 2) % 64].rv    = 1'b1;
                        sched[(g + k + 2) % 64].ridx  = 4'(k);
                        sched[(g + k + 2) % 64].rdata = model_read(a);
                    end else begin
                        sched[(g + k + 1) % 64].wr    = 1'b1;
                        sched[(g + k + 1) % 64].addr  = a;
                        sched[(g + k + 1) % 64].wdata = 16'(wr_seed + 16'(k));
                    end
                end
                if (!V_Wr) begin
                    sched[(g + BURST + 2) % 64].done = 1'b1;
                    free_at = g + BURST + 3;
                end else begin
                    sched[(g + BURST + 1) % 64].done = 1'b1;
                    free_at = g + BURST + 2;
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge Clk1) begin
        exp_t e;
        if (cyc >= 1) begin
            e = sched[cyc % 64];
            check("RD", {31'b0, RD}, {31'b0, e.rd});
            check("WR", {31'b0, WR}, {31'b0, e.wr});
            check("F_Valid", {31'b0, F_Valid}, {31'b0, e.fv});
            check("V_RdValid", {31'b0, V_RdValid}, {31'b0, e.rv});
            check("V_Done", {31'b0, V_Done}, {31'b0, e.done});
            check("rd_and_wr", {31'b0, RD & WR}, 32'd0);
            check("done_and_fvalid", {31'b0, V_Done & F_Valid}, 32'd0);
            if (e.rd || e.wr) check("Addr", {16'b0, Addr}, {16'b0, e.addr});
            if (e.wr)         check("DataOut", {16'b0, DataOut}, {16'b0, e.wdata});
            if (e.chk_idx)    check("V_Idx", {28'b0, V_Idx}, {28'b0, e.vidx});
            if (e.fv)         check("F_Data", {16'b0, F_Data}, {16'b0, e.fdata});
            if (e.rv) begin
                check("V_RdIdx", {28'b0, V_RdIdx}, {28'b0, e.ridx});
                check("V_RdData", {16'b0, V_RdData}, {16'b0, e.rdata});
            end
            if (e.wr) model_mem[e.addr] = e.wdata;
        end
    end

    // ---------------- requesters and observation ----------------
    logic [15:0] rd_addr_q [$];
    logic [15:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    logic [3:0]  rd_idx_q  [$];
    logic [15:0] rd_data_q [$];
    bit          ev_q      [$];   // 0 = F_Valid pulse, 1 = V_Done pulse

    task automatic clear_logs();
        rd_addr_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_idx_q.delete();
        rd_data_q.delete();
        ev_q.delete();
    endtask

    // Advance one cycle; requesters drop their request when served.
    task automatic step();
        @(posedge Clk1);
        #1;
        if (RD === 1'b1) rd_addr_q.push_back(Addr);
        if (WR === 1'b1) begin
            wr_addr_q.push_back(Addr);
            wr_data_q.push_back(DataOut);
        end
        if (V_RdValid === 1'b1) begin
            rd_idx_q.push_back(V_RdIdx);
            rd_data_q.push_back(V_RdData);
        end
        if (F_Valid === 1'b1) begin
            ev_q.push_back(1'b0);
            F_Req = 1'b0;
        end
        if (V_Done === 1'b1) begin
            ev_q.push_back(1'b1);
            V_Req = 1'b0;
        end
    endtask

    task automatic wait_for(input bit want_v, input int budget, output int lat);
        bit seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < budget) begin
            step();
            lat++;
            seen = want_v ? (V_Done === 1'b1) : (F_Valid === 1'b1);
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: no %s pulse within %0d cycles", want_v ? "V_Done" : "F_Valid", budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_RD"}, {31'b0, RD}, 32'd0);
        check({tag, "_WR"}, {31'b0, WR}, 32'd0);
        check({tag, "_F_Valid"}, {31'b0, F_Valid}, 32'd0);
        check({tag, "_V_RdValid"}, {31'b0, V_RdValid}, 32'd0);
        check({tag, "_V_Done"}, {31'b0, V_Done}, 32'd0);
        check({tag, "_Addr"}, {16'b0, Addr}, 32'd0);
        check({tag, "_DataOut"}, {16'b0, DataOut}, 32'd0);
        check({tag, "_F_Data"}, {16'b0, F_Data}, 32'd0);
        check({tag, "_V_RdData"}, {16'b0, V_RdData}, 32'd0);
        check({tag, "_V_Idx"}, {28'b0, V_Idx}, 32'd0);
        check({tag, "_V_RdIdx"}, {28'b0, V_RdIdx}, 32'd0);
    endtask

    initial begin
        int lat;
        int guard;
        logic [15:0] exp_a;

        Reset   = 1'b1;
        F_Req   = 1'b0;
        F_Addr  = 16'h0000;
        V_Req   = 1'b0;
        V_Wr    = 1'b0;
        V_Base  = 16'h0000;
        wr_seed = 16'h0000;

        // Reset state
        repeat (3) step();
        check_reset_outputs("reset");
        Reset = 1'b0;
        repeat (2) step();

        // Single fetch from address 0
        clear_logs();
        F_Addr = 16'h0000;
        F_Req  = 1'b1;
        wait_for(1'b0, 10, lat);
        check("fetch_latency", lat, 32'd3);
        check("fetch_data", {16'b0, F_Data}, 32'h7312);
        check("fetch_rd_cycles", rd_addr_q.size(), 32'd1);
        if (rd_addr_q.size() > 0) check("fetch_rd_addr", {16'b0, rd_addr_q[0]}, 32'h0000);
        repeat (2) step();

        // Vector load from 0x0100, mem[0x100+k] = 3k
        clear_logs();
        V_Base = 16'h0100;
        V_Wr   = 1'b0;
        V_Req  = 1'b1;
        wait_for(1'b1, 40, lat);
        check("vld_latency", lat, 32'd19);
        check("vld_rd_cycles", rd_addr_q.size(), 32'd16);
        check("vld_elems", rd_data_q.size(), 32'd16);
        for (int k = 0; k < 16 && k < rd_addr_q.size(); k++)
            check("vld_rd_addr", {16'b0, rd_addr_q[k]}, 32'h0100 + k);
        for (int k = 0; k < 16 && k < rd_data_q.size(); k++) begin
            check("vld_idx", {28'b0, rd_idx_q[k]}, k);
            check("vld_data", {16'b0, rd_data_q[k]}, 3 * k);
        end
        check("vld_done_count", ev_q.size(), 32'd1);
        repeat (2) step();

        // Vector store wrapping through 0xFFFF
        clear_logs();
        wr_seed = 16'hA000;
        V_Base  = 16'hFFF8;
        V_Wr    = 1'b1;
        V_Req   = 1'b1;
        wait_for(1'b1, 40, lat);
        check("vst_latency", lat, 32'd18);
        check("vst_wr_cycles", wr_addr_q.size(), 32'd16);
        for (int k = 0; k < 16 && k < wr_addr_q.size(); k++) begin
            exp_a = 16'(16'hFFF8 + 16'(k));
            check("vst_addr", {16'b0, wr_addr_q[k]}, {16'b0, exp_a});
            check("vst_data", {16'b0, wr_data_q[k]}, 32'hA000 + k);
        end
        if (wr_addr_q.size() == 16) begin
            check("vst_addr_wrap", {16'b0, wr_addr_q[8]}, 32'h0000);
            check("vst_addr_last", {16'b0, wr_addr_q[15]}, 32'h0007);
        end
        repeat (2) step();

        // Contention from reset: fetch, then vector, then the next fetch
        Reset  = 1'b1;
        F_Addr = 16'h0004;
        F_Req  = 1'b1;
        V_Base = 16'h0200;
        V_Wr   = 1'b0;
        V_Req  = 1'b1;
        step();
        Reset = 1'b0;
        clear_logs();
        wait_for(1'b0, 10, lat);
        F_Addr = 16'h0008;
        F_Req  = 1'b1;
        wait_for(1'b1, 40, lat);
        wait_for(1'b0, 10, lat);
        check("rr_events", ev_q.size(), 32'd3);
        if (ev_q.size() == 3) begin
            check("rr_first_fetch", {31'b0, ev_q[0]}, 32'd0);
            check("rr_then_vector", {31'b0, ev_q[1]}, 32'd1);
            check("rr_then_fetch", {31'b0, ev_q[2]}, 32'd0);
        end
        repeat (2) step();

        // Reset while element 5 of a vector load is addressed
        clear_logs();
        V_Base = 16'h1234;
        V_Wr   = 1'b0;
        V_Req  = 1'b1;
        guard  = 0;
        while (!(RD === 1'b1 && V_Idx == 4'd5) && guard < 30) begin
            step();
            guard++;
        end
        if (guard >= 30) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: element 5 of load never addressed");
        end
        Reset = 1'b1;
        V_Req = 1'b0;
        step();
        check_reset_outputs("midreset");
        Reset = 1'b0;
        ev_q.delete();
        repeat (25) step();
        check("midreset_no_done", ev_q.size(), 32'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            step();
            if ($urandom_range(0, 399) == 0) begin
                Reset = 1'b1;
                F_Req = 1'b0;
                V_Req = 1'b0;
                step();
                Reset = 1'b0;
            end
            if (!F_Req && $urandom_range(0, 3) == 0) begin
                F_Addr = 16'($urandom);
                F_Req  = 1'b1;
            end
            if (!V_Req && $urandom_range(0, 5) == 0) begin
                V_Base  = 16'($urandom);
                V_Wr    = 1'($urandom);
                wr_seed = 16'($urandom);
                V_Req   = 1'b1;
            end
        end
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
